// File: rtl/riscv_aes_round_engine.sv
// riscv_aes_round_engine: iterative AES-128 encryptor, one round per clock, with on-the-fly key expansion.
// Optional RISCV_AES_ABORT_EN adds abort_i to cancel a running operation.
module riscv_aes_round_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
`ifdef RISCV_AES_ABORT_EN
  input  logic                  abort_i,
`endif
  input  logic [DATA_WIDTH-1:0] state_a_i,
  input  logic [DATA_WIDTH-1:0] state_b_i,
  input  logic [DATA_WIDTH-1:0] state_c_i,
  input  logic [DATA_WIDTH-1:0] state_d_i,
  input  logic [DATA_WIDTH-1:0] key_a_i,
  input  logic [DATA_WIDTH-1:0] key_b_i,
  input  logic [DATA_WIDTH-1:0] key_c_i,
  input  logic [DATA_WIDTH-1:0] key_d_i,
  input  logic [DATA_WIDTH-1:0] wb_addr_i,
  output logic                  busy_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_a_o,
  output logic [DATA_WIDTH-1:0] result_b_o,
  output logic [DATA_WIDTH-1:0] result_c_o,
  output logic [DATA_WIDTH-1:0] result_d_o,
  output logic [DATA_WIDTH-1:0] wb_addr_o
);

  if (DATA_WIDTH != 32 || NUM_ROUNDS != 10) begin : g_bad_cfg
    $error("riscv_aes_round_engine supports only DATA_WIDTH=32 and NUM_ROUNDS=10");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                        8'h80, 8'h1b, 8'h36, 40'h0};

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  state_e       fsm_q, fsm_d;
  logic [127:0] data_q, data_d, rkey_q, rkey_d, sr, mc, rk;
  logic [31:0]  addr_q, addr_d, t;
  logic [3:0]   rcnt_q, rcnt_d;
  logic         abort;

`ifdef RISCV_AES_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // SubBytes folded into ShiftRows: row r of column c comes from column (c+r)%4
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-32*c-8*r -: 8] = sb(data_q[127-32*((c+r)%4)-8*r -: 8]);
    mc = {mix(sr[127:96]), mix(sr[95:64]), mix(sr[63:32]), mix(sr[31:0])};
    t = {sb(rkey_q[23:16]), sb(rkey_q[15:8]), sb(rkey_q[7:0]), sb(rkey_q[31:24])} ^ {RCON[rcnt_q], 24'h0};
    rk[127:96] = rkey_q[127:96] ^ t;
    rk[95:64]  = rkey_q[95:64] ^ rk[127:96];
    rk[63:32]  = rkey_q[63:32] ^ rk[95:64];
    rk[31:0]   = rkey_q[31:0] ^ rk[63:32];
  end

  always_comb begin
    fsm_d  = fsm_q;
    data_d = data_q;
    rkey_d = rkey_q;
    addr_d = addr_q;
    rcnt_d = rcnt_q;
    case (fsm_q)
      IDLE: if (start_i) begin
        data_d = {state_a_i, state_b_i, state_c_i, state_d_i} ^ {key_a_i, key_b_i, key_c_i, key_d_i};
        rkey_d = {key_a_i, key_b_i, key_c_i, key_d_i};
        addr_d = wb_addr_i;
        rcnt_d = 4'd1;
        fsm_d  = ROUND;
      end
      ROUND: begin
        data_d = mc ^ rk;
        rkey_d = rk;
        rcnt_d = rcnt_q + 4'd1;
        fsm_d  = (rcnt_q == 4'd9) ? FINAL : ROUND;
      end
      FINAL: begin
        data_d = sr ^ rk;
        rkey_d = rk;
        fsm_d  = DONE;
      end
      default: fsm_d = out_ready_i ? IDLE : DONE;
    endcase
    if (abort && fsm_q != IDLE) begin
      fsm_d  = IDLE;
      data_d = '0;
      rkey_d = '0;
      addr_d = '0;
      rcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm_q  <= IDLE;
      data_q <= '0;
      rkey_q <= '0;
      addr_q <= '0;
      rcnt_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      data_q <= data_d;
      rkey_q <= rkey_d;
      addr_q <= addr_d;
      rcnt_q <= rcnt_d;
    end

  assign busy_o      = fsm_q != IDLE;
  assign out_valid_o = fsm_q == DONE;
  assign {result_a_o, result_b_o, result_c_o, result_d_o} = out_valid_o ? data_q : '0;
  assign wb_addr_o   = out_valid_o ? addr_q : '0;

endmodule

// File: tb/tb_riscv_aes_round_engine.sv
// tb_riscv_aes_round_engine: directed FIPS-197 vectors, backpressure, ignored starts and reset/abort cases.
module tb_riscv_aes_round_engine;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, out_ready_i = 1'b1;
  logic [127:0] pt = '0, key = '0, res;
  logic [31:0]  addr = '0;
  logic         busy_o, out_valid_o;
  logic [31:0]  result_a_o, result_b_o, result_c_o, result_d_o, wb_addr_o;
  int           n_chk = 0, n_fail = 0, n;
`ifdef RISCV_AES_ABORT_EN
  logic         abort_i = 1'b0;
`endif

  always #5 clk = ~clk;

  riscv_aes_round_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
`ifdef RISCV_AES_ABORT_EN
    .abort_i(abort_i),
`endif
    .state_a_i(pt[127:96]), .state_b_i(pt[95:64]), .state_c_i(pt[63:32]), .state_d_i(pt[31:0]),
    .key_a_i(key[127:96]), .key_b_i(key[95:64]), .key_c_i(key[63:32]), .key_d_i(key[31:0]),
    .wb_addr_i(addr), .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_a_o(result_a_o), .result_b_o(result_b_o), .result_c_o(result_c_o),
    .result_d_o(result_d_o), .wb_addr_o(wb_addr_o)
  );

  assign res = {result_a_o, result_b_o, result_c_o, result_d_o};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [127:0] k, input logic [127:0] p, input logic [31:0] a);
    key = k;
    pt = p;
    addr = a;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid_o && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #2;
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_valid", 128'(out_valid_o), 128'(0));
    chk("rst_result", res, '0);
    chk("rst_addr", 128'(wb_addr_o), '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 128'(busy_o), 128'(0));

    // C.1 vector, ready high
    start_op(K1, P1, 32'h0000_1000);
    chk("c1_busy", 128'(busy_o), 128'(1));
    wait_valid(n);
    chk("c1_latency", 128'(n), 128'(10));
    chk("c1_result", res, C1);
    chk("c1_addr", 128'(wb_addr_o), 128'(32'h0000_1000));
    tick();
    chk("c1_idle_valid", 128'(out_valid_o), 128'(0));
    chk("c1_idle_busy", 128'(busy_o), 128'(0));
    chk("c1_idle_result", res, '0);

    // Appendix B vector
    start_op(K2, P2, 32'h0000_2000);
    wait_valid(n);
    chk("c2_latency", 128'(n), 128'(10));
    chk("c2_result", res, C2);
    chk("c2_addr", 128'(wb_addr_o), 128'(32'h0000_2000));
    tick();

    // backpressure for 20 cycles
    out_ready_i = 1'b0;
    start_op(K1, P1, 32'h0000_1000);
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 128'(out_valid_o), 128'(1));
      chk("bp_result", res, C1);
      chk("bp_addr", 128'(wb_addr_o), 128'(32'h0000_1000));
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    chk("bp_busy_drop", 128'(busy_o), 128'(0));
    chk("bp_valid_drop", 128'(out_valid_o), 128'(0));

    // starts while busy and input changes after capture are ignored
    out_ready_i = 1'b0;
    start_op(K1, P1, 32'h0000_1000);
    key = K2;
    tick();
    tick();
    start_op(K2, P2, 32'h0000_3000);
    wait_valid(n);
    chk("ign_result", res, C1);
    chk("ign_addr", 128'(wb_addr_o), 128'(32'h0000_1000));
    out_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("ign_hs_busy", 128'(busy_o), 128'(0));
    tick();
    chk("ign_no_second", 128'(busy_o), 128'(0));

    // reset in the middle of an operation
    start_op(K1, P1, 32'h0000_1000);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy_o), 128'(0));
    chk("mid_rst_valid", 128'(out_valid_o), 128'(0));
    chk("mid_rst_result", res, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 128'(busy_o), 128'(0));
    start_op(K2, P2, 32'h0000_2000);
    wait_valid(n);
    chk("post_rst_latency", 128'(n), 128'(10));
    chk("post_rst_result", res, C2);
    tick();

`ifdef RISCV_AES_ABORT_EN
    start_op(K2, P2, 32'h0000_4000);
    repeat (5) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", 128'(busy_o), 128'(0));
    chk("abort_valid", 128'(out_valid_o), 128'(0));
    tick();
    start_op(K1, P1, 32'h0000_1000);
    wait_valid(n);
    chk("abort_latency", 128'(n), 128'(10));
    chk("abort_result", res, C1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
